// File: rtl/mio_pkg.sv
// Shared types, constants and the address-region decode for the memory/IO bridge.
package mio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAM_WAIT = 2'd1,
        ST_PERI_REQ = 2'd2,
        ST_DONE     = 2'd3
    } mio_state_e;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;
    localparam int unsigned CNT_W        = 8;

    function automatic logic is_peri_region(input logic [31:0] byte_addr, input logic [3:0] base);
        return (byte_addr[31:28] >= base);
    endfunction

endpackage

// File: rtl/mio_wait_cnt.sv
// Loadable down-counter with a terminal flag; times RAM latency and peripheral timeout.
module mio_wait_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         term_o
);

    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = W'(0);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != ZERO)) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == ONE);

endmodule

// File: rtl/mio_bridge.sv
// Memory/IO bridge: routes one CPU access at a time to on-chip RAM or the peripheral bus.
// Optional peripheral ack timeout enabled by defining MIO_TIMEOUT_EN.
import mio_pkg::*;

module mio_bridge #(
    parameter int unsigned RAM_LAT   = 2,
    parameter int unsigned ADDR_W    = 10,
    parameter logic [3:0]  PERI_BASE = 4'hE,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic              cpu_mio,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mio_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              peri_req,
    output logic              peri_we,
    output logic [31:0]       peri_addr,
    output logic [31:0]       peri_wdata,
    input  logic [31:0]       peri_rdata,
    input  logic              peri_ack,
    output logic              bus_err
);

    mio_state_e        state_q;
    logic              we_q;
    logic [31:0]       rdata_q;
    logic              mio_ready_q;
    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic              peri_req_q;
    logic              peri_we_q;
    logic [31:0]       peri_addr_q;
    logic [31:0]       peri_wdata_q;
    logic              bus_err_q;

    logic              req_s;
    logic              peri_s;
    logic              load_s;
    logic              dec_s;
    logic              cnt_term_s;
    logic [CNT_W-1:0]  load_val_s;

    assign req_s  = cpu_mio & (mem_r | mem_w);
    assign peri_s = is_peri_region(addr, PERI_BASE);
    assign load_s = (state_q == ST_IDLE) && req_s;
    assign dec_s  = (state_q == ST_RAM_WAIT) || (state_q == ST_PERI_REQ);

    // Counter preload: fixed RAM latency or the peripheral ack budget.
    always_comb begin
        load_val_s = CNT_W'(RAM_LAT);
        if (peri_s) begin
            load_val_s = CNT_W'(TIMEOUT);
        end else begin
            load_val_s = CNT_W'(RAM_LAT);
        end
    end

    mio_wait_cnt #(
        .W (CNT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .dec_i      (dec_s),
        .term_o     (cnt_term_s)
    );

    // Transaction FSM with registered bus strobes and completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            mio_ready_q  <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= {ADDR_W{1'b0}};
            ram_wdata_q  <= 32'h0000_0000;
            peri_req_q   <= 1'b0;
            peri_we_q    <= 1'b0;
            peri_addr_q  <= 32'h0000_0000;
            peri_wdata_q <= 32'h0000_0000;
            bus_err_q    <= 1'b0;
        end else begin
            mio_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        // A simultaneous read and write resolves to the write.
                        we_q <= mem_w;
                        if (peri_s) begin
                            state_q      <= ST_PERI_REQ;
                            peri_req_q   <= 1'b1;
                            peri_we_q    <= mem_w;
                            peri_addr_q  <= addr;
                            peri_wdata_q <= wdata;
                        end else begin
                            state_q     <= ST_RAM_WAIT;
                            ram_en_q    <= 1'b1;
                            ram_we_q    <= mem_w;
                            ram_addr_q  <= addr[ADDR_W+1:2];
                            ram_wdata_q <= wdata;
                        end
                    end
                end
                ST_RAM_WAIT: begin
                    if (cnt_term_s) begin
                        if (!we_q) begin
                            rdata_q <= ram_rdata;
                        end
                        ram_en_q    <= 1'b0;
                        ram_we_q    <= 1'b0;
                        mio_ready_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_PERI_REQ: begin
                    if (peri_ack) begin
                        if (!we_q) begin
                            rdata_q <= peri_rdata;
                        end
                        peri_req_q  <= 1'b0;
                        peri_we_q   <= 1'b0;
                        mio_ready_q <= 1'b1;
                        state_q     <= ST_DONE;
`ifdef MIO_TIMEOUT_EN
                    end else if (cnt_term_s) begin
                        if (!we_q) begin
                            rdata_q <= BUS_ERR_DATA;
                        end
                        peri_req_q  <= 1'b0;
                        peri_we_q   <= 1'b0;
                        mio_ready_q <= 1'b1;
                        bus_err_q   <= 1'b1;
                        state_q     <= ST_DONE;
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata      = rdata_q;
    assign mio_ready  = mio_ready_q;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign peri_req   = peri_req_q;
    assign peri_we    = peri_we_q;
    assign peri_addr  = peri_addr_q;
    assign peri_wdata = peri_wdata_q;
`ifdef MIO_TIMEOUT_EN
    assign bus_err    = bus_err_q;
`else
    assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bridge.sv
// Self-checking bench for mio_bridge: transaction-level timing model compared every cycle.
module tb_mio_bridge;

    localparam int RAM_LAT = 2;
    localparam int TO      = 8;
    localparam int NEVER   = 1 << 30;

    logic        clk = 1'b0;
    logic        reset, mem_r, mem_w, cpu_mio;
    logic [31:0] addr, wdata, rdata;
    logic        mio_ready, ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        peri_req, peri_we, peri_ack, bus_err;
    logic [31:0] peri_addr, peri_wdata, peri_rdata;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    bit preload = 1'b1;

    logic [31:0] ram_mem [0:1023];
    logic [31:0] shadow  [0:1023];

    // Transaction model: strobes busy for m_start < cyc < m_end, pulse at m_ready.
    int          m_start = -10;
    int          m_end   = -10;
    int          m_ready = -10;
    bit          m_ram   = 1'b1;
    bit          m_we    = 1'b1;
    bit          m_err   = 1'b0;
    logic [31:0] m_addr  = 32'h0;
    logic [31:0] m_wd    = 32'h0;
    logic [31:0] m_rd_old = 32'h0;
    logic [31:0] m_rd_new = 32'h0;

    mio_bridge #(
        .RAM_LAT   (RAM_LAT),
        .ADDR_W    (10),
        .PERI_BASE (4'hE),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_r      (mem_r),
        .mem_w      (mem_w),
        .cpu_mio    (cpu_mio),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .mio_ready  (mio_ready),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .peri_req   (peri_req),
        .peri_we    (peri_we),
        .peri_addr  (peri_addr),
        .peri_wdata (peri_wdata),
        .peri_rdata (peri_rdata),
        .peri_ack   (peri_ack),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Simple RAM: data presented while enabled, writes land on the clock.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= 32'h0;
            ram_mem[4] <= 32'h1234_5678;
        end else if (ram_en && ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = ram_en ? ram_mem[ram_addr] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input int c);
        return (c >= m_ready && !m_we) ? m_rd_new : m_rd_old;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit busy;
            busy = (cyc > m_start) && (cyc < m_end);
            chk("mio_ready", {31'h0, mio_ready}, {31'h0, cyc == m_ready});
            chk("bus_err",   {31'h0, bus_err},   {31'h0, (cyc == m_ready) && m_err});
            chk("ram_en",    {31'h0, ram_en},    {31'h0, busy && m_ram});
            chk("ram_we",    {31'h0, ram_we},    {31'h0, busy && m_ram && m_we});
            chk("peri_req",  {31'h0, peri_req},  {31'h0, busy && !m_ram});
            chk("peri_we",   {31'h0, peri_we},   {31'h0, busy && !m_ram && m_we});
            chk("rdata",     rdata,              exp_rdata(cyc));
            if (busy && m_ram) begin
                chk("ram_addr", {22'h0, ram_addr}, (m_addr >> 2) & 32'h3FF);
                if (m_we) chk("ram_wdata", ram_wdata, m_wd);
            end
            if (busy && !m_ram) begin
                chk("peri_addr", peri_addr, m_addr);
                if (m_we) chk("peri_wdata", peri_wdata, m_wd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        int n = 0;
        while (cyc < c && n < 500) begin
            step();
            n++;
        end
        if (cyc != c) begin
            errors++;
            checks++;
            $display("FAIL wait_bound cyc=%0d wanted=%0d", cyc, c);
        end
    endtask

    // Present a request for one sampling edge (or keep it held) and update the model.
    task automatic start(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input bit hold);
        int word;
        m_rd_old = exp_rdata(cyc);
        mem_r = r; mem_w = w; cpu_mio = 1'b1; addr = a; wdata = d;
        m_start = cyc; m_we = w; m_addr = a; m_wd = d; m_err = 1'b0;
        m_ram = (a[31:28] < 4'hE);
        word = int'((a >> 2) & 32'h3FF);
        if (m_ram) begin
            m_ready  = cyc + RAM_LAT + 1;
            m_end    = m_ready;
            m_rd_new = shadow[word];
            if (w) shadow[word] = d;
        end else begin
            m_ready  = NEVER;
            m_end    = NEVER;
            m_rd_new = 32'h0;
        end
        step();
        if (!hold) begin
            mem_r = 1'b0; mem_w = 1'b0;
            addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD;
        end
    endtask

    task automatic ack_at(input int k, input logic [31:0] d);
        goto(k);
        peri_ack = 1'b1; peri_rdata = d;
        m_ready = k + 1; m_end = k + 1; m_rd_new = d;
        step();
        peri_ack = 1'b0; peri_rdata = 32'h0;
    endtask

    initial begin
        int s;
        reset = 1'b1; mem_r = 1'b0; mem_w = 1'b0; cpu_mio = 1'b1;
        addr = 32'h0; wdata = 32'h0; peri_ack = 1'b0; peri_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) shadow[i] = 32'h0;
        shadow[4] = 32'h1234_5678;
        step(); step(); step();
        chk("rst_rdata",     rdata,               32'h0);
        chk("rst_ready",     {31'h0, mio_ready},  32'h0);
        chk("rst_ram_en",    {31'h0, ram_en},     32'h0);
        chk("rst_peri_req",  {31'h0, peri_req},   32'h0);
        chk("rst_peri_addr", peri_addr,           32'h0);
        chk("rst_ram_addr",  {22'h0, ram_addr},   32'h0);
        reset = 1'b0; preload = 1'b0;
        step();
        chk_en = 1'b1;

        // RAM read of word 4: pulse three cycles after the request cycle.
        s = cyc;
        start(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        chk("t1_ram_addr", {22'h0, ram_addr}, 32'd4);
        goto(s + 3);
        chk("t1_ready", {31'h0, mio_ready}, 32'd1);
        chk("t1_rdata", rdata, 32'h1234_5678);
        step();

        // RAM write with the request bus scrambled right after sampling.
        s = cyc;
        start(1'b0, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 1'b0);
        chk("t2_ram_wdata", ram_wdata, 32'hA5A5_A5A5);
        goto(s + 3);
        chk("t2_rdata_kept", rdata, 32'h1234_5678);
        step();

        s = cyc;
        start(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
        goto(s + 3);
        chk("t2_readback", rdata, 32'hA5A5_A5A5);
        step();

        // Read and write together: the write is performed.
        s = cyc;
        start(1'b1, 1'b1, 32'h0000_0020, 32'h0F0F_0F0F, 1'b0);
        goto(s + 4);
        s = cyc;
        start(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
        goto(s + 3);
        chk("both_readback", rdata, 32'h0F0F_0F0F);
        step();

        // Requests ignored while the CPU does not own the bus.
        mem_r = 1'b1; cpu_mio = 1'b0; addr = 32'h0000_0010;
        step(); step(); step();
        mem_r = 1'b0; cpu_mio = 1'b1;
        step();

        // Peripheral read, ack five cycles after the request cycle.
        s = cyc;
        start(1'b1, 1'b0, 32'hE000_0004, 32'h0, 1'b0);
        ack_at(s + 5, 32'h0000_CAFE);
        chk("t3_ready",    {31'h0, mio_ready}, 32'd1);
        chk("t3_rdata",    rdata, 32'h0000_CAFE);
        chk("t3_req_low",  {31'h0, peri_req}, 32'd0);
        step();

        // Peripheral write acked in its first request cycle.
        s = cyc;
        start(1'b0, 1'b1, 32'hF000_0100, 32'h0000_55AA, 1'b0);
        ack_at(s + 1, 32'h1111_1111);
        step();

        // Stray ack while idle.
        peri_ack = 1'b1; peri_rdata = 32'h2222_2222;
        step(); step();
        peri_ack = 1'b0; peri_rdata = 32'h0;
        step();

        // Read held through completion, then an immediate back-to-back access.
        s = cyc;
        start(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
        goto(s + 3);
        step();
        mem_r = 1'b0;
        s = cyc;
        start(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
        goto(s + 3);
        chk("t4_b2b_rdata", rdata, 32'hA5A5_A5A5);
        step(); step();

        // Reset during a peripheral request, ack one cycle later.
        s = cyc;
        start(1'b1, 1'b0, 32'hE000_0008, 32'h0, 1'b0);
        goto(s + 2);
        reset = 1'b1;
        step();
        reset = 1'b0; peri_ack = 1'b1; peri_rdata = 32'h0BAD_F00D;
        m_end = cyc; m_ready = -10; m_rd_old = 32'h0; m_rd_new = 32'h0;
        step();
        peri_ack = 1'b0; peri_rdata = 32'h0;
        chk("t5_req_low", {31'h0, peri_req}, 32'd0);
        chk("t5_no_ready", {31'h0, mio_ready}, 32'd0);
        chk("t5_rdata", rdata, 32'h0);
        step(); step();

        // Bridge is idle again after the abort.
        s = cyc;
        start(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
        goto(s + 3);
        chk("t5_recover", rdata, 32'h0F0F_0F0F);
        step();

`ifdef MIO_TIMEOUT_EN
        // Peripheral never acks: timeout completion with error data.
        s = cyc;
        start(1'b1, 1'b0, 32'hE000_0040, 32'h0, 1'b0);
        m_ready = s + TO + 1; m_end = m_ready; m_err = 1'b1; m_rd_new = 32'hDEAD_BEEF;
        goto(s + TO + 1);
        chk("t6_bus_err", {31'h0, bus_err}, 32'd1);
        chk("t6_ready",   {31'h0, mio_ready}, 32'd1);
        chk("t6_rdata",   rdata, 32'hDEAD_BEEF);
        step();
`endif

        step(); step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
